// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches and memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 128
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_ren;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between the I-side and D-side cache miss logic; all outputs registered.
// Define ROUND_ROBIN_EN for alternating grants on contention; otherwise D has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 128
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

    state_t state, next_state;

    logic              d_pend;
    logic              pick_d;
    logic              pick_i;
    logic              grant_d;
    logic              grant_i;
    logic              done;

    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_ready_q;
    logic              d_ready_q;

    assign d_pend = bus.d_ren | bus.d_wen;

`ifdef ROUND_ROBIN_EN
    // last_grant: 0 = I side, 1 = D side; D wins contention only if I went last
    logic last_grant;
    assign pick_d = d_pend & (~bus.i_req | ~last_grant);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b0;
        end else if (grant_d) begin
            last_grant <= 1'b1;
        end else if (grant_i) begin
            last_grant <= 1'b0;
        end
    end
`else
    assign pick_d = d_pend;
`endif

    assign pick_i = bus.i_req & ~pick_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // RESP always returns to IDLE so a still-held request is not served twice
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    next_state = D_BUSY;
                end else if (pick_i) begin
                    next_state = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.mem_ready) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        done    = 1'b0;
        if (state == IDLE) begin
            grant_d = pick_d;
            grant_i = pick_i;
        end
        if ((state == I_BUSY) || (state == D_BUSY)) begin
            done = bus.mem_ready;
        end
    end

    // mem_write_q still marks a D write in progress when completion arrives, so d_rdata is kept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            if (grant_d) begin
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
                mem_write_q <= bus.d_wen;
                mem_read_q  <= bus.d_ren & ~bus.d_wen;
            end
            if (grant_i) begin
                mem_addr_q  <= bus.i_addr;
                mem_read_q  <= 1'b1;
                mem_write_q <= 1'b0;
            end
            if (done) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                if (state == I_BUSY) begin
                    i_rdata_q <= bus.mem_rdata;
                    i_ready_q <= 1'b1;
                end else begin
                    if (!mem_write_q) begin
                        d_rdata_q <= bus.mem_rdata;
                    end
                    d_ready_q <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of the arbitration rules.
// Requesters hold requests until their ready pulse; memory asserts mem_ready at random, including when idle.
module tb_mem_arbiter;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 128;
    localparam int N_CYCLES = 4000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: one outstanding transaction, plus a response cycle after it completes
    bit                txn_active;
    bit                txn_done;
    bit                txn_side_d;
    bit                txn_write;
    logic [ADDR_W-1:0] exp_mem_addr;
    logic [DATA_W-1:0] exp_mem_wdata;
    logic [DATA_W-1:0] exp_i_rdata;
    logic [DATA_W-1:0] exp_d_rdata;
`ifdef ROUND_ROBIN_EN
    bit                last_was_d;
`endif

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                               input logic [DATA_W-1:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic modelReset();
        txn_active    = 1'b0;
        txn_done      = 1'b0;
        txn_side_d    = 1'b0;
        txn_write     = 1'b0;
        exp_mem_addr  = '0;
        exp_mem_wdata = '0;
        exp_i_rdata   = '0;
        exp_d_rdata   = '0;
`ifdef ROUND_ROBIN_EN
        last_was_d    = 1'b0;
`endif
    endtask

    // Advances the model across the coming clock edge using the inputs now driven
    task automatic modelStep();
        bit d_wants;
        bit i_wants;
        bit take_d;
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (txn_done) begin
            txn_done = 1'b0;
        end else if (txn_active) begin
            if (bus.mem_ready) begin
                txn_active = 1'b0;
                txn_done   = 1'b1;
                if (!txn_side_d) begin
                    exp_i_rdata = bus.mem_rdata;
                end else if (!txn_write) begin
                    exp_d_rdata = bus.mem_rdata;
                end
            end
        end else begin
            d_wants = bus.d_ren | bus.d_wen;
            i_wants = bus.i_req;
            if (d_wants && i_wants) begin
`ifdef ROUND_ROBIN_EN
                take_d = !last_was_d;
`else
                take_d = 1'b1;
`endif
            end else begin
                take_d = d_wants;
            end
            if (d_wants || i_wants) begin
                txn_active = 1'b1;
                txn_side_d = take_d;
                txn_write  = take_d && bus.d_wen;
                if (take_d) begin
                    exp_mem_addr  = bus.d_addr;
                    exp_mem_wdata = bus.d_wdata;
                end else begin
                    exp_mem_addr = bus.i_addr;
                end
`ifdef ROUND_ROBIN_EN
                last_was_d = take_d;
`endif
            end
        end
    endtask

    task automatic applyStimulus(input int cyc);
        bit i_done;
        bit d_done;
        int kind;
        i_done = txn_done && !txn_side_d;
        d_done = txn_done && txn_side_d;

        if (!bus.i_req || i_done) begin
            bus.i_req  = ($urandom_range(0, 2) == 0);
            bus.i_addr = ADDR_W'($urandom());
        end else if ($urandom_range(0, 3) == 0) begin
            bus.i_addr = ADDR_W'($urandom());
        end

        if (!(bus.d_ren || bus.d_wen) || d_done) begin
            kind = $urandom_range(0, 5);
            bus.d_ren   = (kind == 0) || (kind == 2);
            bus.d_wen   = (kind == 1) || (kind == 2);
            bus.d_addr  = ADDR_W'($urandom());
            bus.d_wdata = rand_data();
        end else if ($urandom_range(0, 3) == 0) begin
            bus.d_addr  = ADDR_W'($urandom());
            bus.d_wdata = rand_data();
        end

        bus.mem_ready = ($urandom_range(0, 2) == 0);
        bus.mem_rdata = rand_data();
        rst_n = ($urandom_range(0, 149) != 0);

        if (cyc < 2) begin
            rst_n         = 1'b0;
            bus.i_req     = 1'b1;
            bus.mem_ready = 1'b1;
        end
    endtask

    task automatic checkCycle();
        checkOutput("mem_read",  DATA_W'(bus.mem_read),  DATA_W'(txn_active && !txn_write));
        checkOutput("mem_write", DATA_W'(bus.mem_write), DATA_W'(txn_active && txn_write));
        checkOutput("mem_addr",  DATA_W'(bus.mem_addr),  DATA_W'(exp_mem_addr));
        checkOutput("mem_wdata", bus.mem_wdata,          exp_mem_wdata);
        checkOutput("i_ready",   DATA_W'(bus.i_ready),   DATA_W'(txn_done && !txn_side_d));
        checkOutput("d_ready",   DATA_W'(bus.d_ready),   DATA_W'(txn_done && txn_side_d));
        checkOutput("i_rdata",   bus.i_rdata,            exp_i_rdata);
        checkOutput("d_rdata",   bus.d_rdata,            exp_d_rdata);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_ren     = 1'b0;
        bus.d_wen     = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        modelReset();

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            applyStimulus(cyc);
            modelStep();
            @(posedge clk);
            #1;
            checkCycle();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external memory port between the instruction-fetch side and the data side of the pipelined RISC-V core. Sits between the I-cache/D-cache miss logic and the memory interface. Grants one requester at a time, registers its address and write data, and holds the memory command until the memory completes. It then returns read data with a one-cycle ready pulse.

## Interface
- ADDR_W, 30: word/line address width.
- DATA_W, 128: memory transfer width (one cache line).
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i_req  input  1  I-side read request; held until i_ready.
- i_addr  input  ADDR_W  I-side address.
- i_rdata  output  DATA_W  I-side read data; valid when i_ready.
- i_ready  output  1  one-cycle completion pulse to I-side.
- d_ren  input  1  D-side read request; held until d_ready.
- d_wen  input  1  D-side write request; held until d_ready.
- d_addr  input  ADDR_W  D-side address.
- d_wdata  input  DATA_W  D-side write data.
- d_rdata  output  DATA_W  D-side read data; valid when d_ready on a read.
- d_ready  output  1  one-cycle completion pulse to D-side.
- mem_read  output  1  memory read command, held until mem_ready.
- mem_write  output  1  memory write command, held until mem_ready.
- mem_addr  output  ADDR_W  registered memory address.
- mem_wdata  output  DATA_W  registered memory write data.
- mem_rdata  input  DATA_W  memory read data; valid when mem_ready.
- mem_ready  input  1  memory completion; may assert any cycle after command, or never.

## Operation
- States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE: sample requests.
  - D pending (d_ren|d_wen) and I pending: grant per priority rule (Configuration).
  - Only one pending: grant it.
  - Grant to D: go to D_BUSY. Latch d_addr and d_wdata. mem_write=d_wen; mem_read=d_ren&~d_wen, so write wins if both are asserted.
  - Grant to I: go to I_BUSY. Latch i_addr. mem_read=1.
- I_BUSY/D_BUSY:
  - Hold mem_* stable.
  - Ignore all requester inputs; changes to them are not observed.
  - On mem_ready: capture mem_rdata into the owner's rdata register, drop mem_read/mem_write, assert the owner's ready, and go to RESP.
- RESP: owner's ready=1 for exactly this cycle. No grant is made here. Next state is IDLE. The same still-held request is therefore never double-served.
- i_rdata/d_rdata hold their last captured value until the next capture for that side.
- A write transaction leaves d_rdata unchanged.
- mem_ready in IDLE or RESP is ignored.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE. mem_read, mem_write, i_ready, d_ready=0. mem_addr, mem_wdata, i_rdata, d_rdata=0.
- Reset mid-transaction aborts with no ready pulse. The requester must reissue.
- Request seen in IDLE at edge N: mem_read/mem_write high after edge N.
- mem_ready high at edge M: requester ready high after edge M for one cycle. IDLE after edge M+1.
- Minimum round trip for a mem_ready that asserts one cycle after command: 3 cycles from request to ready pulse.
- Back-to-back: earliest next grant is the IDLE cycle after RESP. Throughput is at most one transaction per 3 cycles plus memory latency.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- ROUND_ROBIN_EN defined:
  - A 1-bit last_grant register, reset to I, records the side granted most recently.
  - On contention, grant the side not equal to last_grant.
- ROUND_ROBIN_EN undefined:
  - Fixed priority: D side always wins contention.
  - I side may starve under continuous D traffic.
  - No last_grant register is present.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with i_req=1 and mem_ready=1. Required: all outputs 0, no mem command. Release: mem_read=1 and mem_addr=i_addr on the next cycle.
- I read: i_req=1, i_addr=0x0000_0040, memory returns 0xDEAD..BEEF 4 cycles after command. Required: one-cycle i_ready pulse with i_rdata=0xDEAD..BEEF; d_ready stays 0.
- D write: d_wen=1, d_addr=0x100, d_wdata=0x1234. Required: mem_write=1, mem_read=0, mem_wdata=0x1234 held until mem_ready; d_ready pulses; d_rdata unchanged.
- Contention: i_req and d_ren asserted together three times in a row, each held until its ready. Without ROUND_ROBIN_EN the grant order is D,I,D,I... once D drops. With ROUND_ROBIN_EN the first grant is D (last_grant=I at reset), then grants alternate I,D.
- Reset mid-op: assert rst_n=0 while in D_BUSY, before mem_ready. Required: no d_ready pulse; mem_write=0 after the edge; state IDLE.
- Stray mem_ready: pulse mem_ready in IDLE with no request. Required: no ready pulse and no rdata change.
